mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage. It consumes ex_mem_regs_t (alu_out, read_data2, inst_rd, wb_ctrl, mem_ctrl) and produces mem_wb_regs_t for writeback.
- It owns the EX/MEM pipeline register and a request/grant/response data-memory port.
- It stalls the upstream pipeline while a load or store is outstanding.
- It performs store byte-lane steering and load extract/extension.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in WAIT before the bus-error flag; used only with MEM_STAGE_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_ex_mem_regs  in  ex_mem_regs_t  execute-stage result
- i_valid  in  1  i_ex_mem_regs holds a live instruction
- o_stall  out  1  upstream must hold its outputs; capture is blocked
- o_dmem_req  out  1  memory request strobe
- o_dmem_we  out  1  1 = store, 0 = load
- o_dmem_addr  out  64  doubleword-aligned address (alu_out with [2:0] zeroed)
- o_dmem_wdata  out  64  store data, lane-shifted
- o_dmem_be  out  8  byte enables
- i_dmem_gnt  in  1  request accepted this cycle
- i_dmem_rvalid  in  1  response valid (load data or store ack)
- i_dmem_rdata  in  64  load data
- o_mem_wb_regs  out  mem_wb_regs_t  {alu_out, mem_data, inst_rd, wb_ctrl}
- o_wb_valid  out  1  o_mem_wb_regs is valid this cycle (single-cycle pulse per instruction)
- o_misaligned  out  1  pulse: access not naturally aligned; no bus traffic issued
- o_bus_err  out  1  pulse: timeout (only with MEM_STAGE_TIMEOUT_EN, else tied 0)

Behaviour:
- Reset: FSM=IDLE, pipeline register valid=0, and all of the following are 0:
  - o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata
  - o_wb_valid, o_mem_wb_regs, o_misaligned, o_bus_err
- Reset mid-transaction abandons the access. A late i_dmem_rvalid after reset is ignored while in IDLE.
- Capture: when !o_stall && i_valid, register i_ex_mem_regs; when !o_stall && !i_valid, clear register valid.
- FSM states:
  - IDLE
  - REQ: o_dmem_req=1, held stable until i_dmem_gnt
  - WAIT: awaiting i_dmem_rvalid
- FSM transitions:
  - IDLE, registered op neither read nor write: o_wb_valid=1 next cycle, mem_data=0, no stall. Latency 1.
  - IDLE, read/write, aligned: go to REQ. The o_stall combinational term is high from the cycle the access is registered until the cycle rvalid is seen.
  - REQ with gnt: go to WAIT. Gnt and rvalid in the same cycle go directly to IDLE and complete.
  - WAIT with rvalid: go to IDLE. Next cycle o_wb_valid=1 and o_mem_wb_regs.mem_data is the extended load data (0 for stores). Stall drops in the rvalid cycle, so the next instruction is captured that edge.
  - Minimum load/store latency: 2 cycles (req+gnt+rvalid same cycle).
- Alignment: size BYTE any address; HALF requires a[0]=0; WORD requires a[1:0]=0; DWORD requires a[2:0]=0.
  - Violation: o_misaligned pulses one cycle and o_wb_valid pulses with wb_ctrl.reg_write forced 0.
  - No bus request, no stall beyond the capture cycle.
- Store lanes: off=a[2:0].
  - BYTE: be=8'h01<<off, wdata=rd2[7:0] replicated to all bytes.
  - HALF: be=8'h03<<off, wdata=rd2[15:0] replicated.
  - WORD: be=8'h0F<<off, wdata=rd2[31:0] replicated.
  - DWORD: be=8'hFF, wdata=rd2.
- Loads: be=8'hFF. Extract rdata>>(8*off), truncate to size, then sign-extend to 64 bits (or zero-extend if mem_ctrl.is_unsigned).
- alu_out, inst_rd and wb_ctrl pass through unchanged into o_mem_wb_regs.

Optional Feature:
- MEM_STAGE_TIMEOUT_EN defined: an 8+ bit counter starts on entering REQ.
  - If not back in IDLE after TIMEOUT_CYCLES cycles: o_bus_err pulses, FSM returns to IDLE, o_wb_valid pulses with reg_write forced 0, stall releases.
- Undefined: no counter, FSM waits indefinitely, o_bus_err tied 0.

Decomposition:
- rv_pkg additions:
  - mem_size_t {MEM_B, MEM_H, MEM_W, MEM_D}
  - mem_ctrl_t {mem_read, mem_write, mem_size_t size, is_unsigned}
  - mem_wb_regs_t
  - mem_fsm_t {MEM_IDLE, MEM_REQ, MEM_WAIT}
- Sub-module mem_lane_align (combinational): store be/wdata steering and load extract/extend. Reusable by a future cache.

Test Plan:
- ALU op (no mem), alu_out=64'h1234 -> o_wb_valid 1 cycle later, o_mem_wb_regs.alu_out=64'h1234, mem_data=0, o_stall never asserted.
- LB unsigned=0, addr=64'h1003, rdata=64'h0000_0000_8000_0000 (byte3=0x80), gnt+rvalid same cycle -> mem_data=64'hFFFF_FFFF_FFFF_FF80, be=8'hFF, total 2 cycles.
- SH addr=64'h2006, rd2=64'hABCD, gnt after 3 cycles, rvalid 2 later -> be=8'hC0, wdata=64'hABCD_ABCD_ABCD_ABCD, addr=64'h2000, req held stable 3 cycles, o_stall high throughout, drops in rvalid cycle.
- LW addr=64'h1002 -> o_misaligned pulse, o_dmem_req never asserted, o_wb_valid with reg_write=0.
- LD in WAIT, i_rst asserted -> all outputs 0 next cycle. A subsequent stray rvalid produces no o_wb_valid.
- With MEM_STAGE_TIMEOUT_EN, TIMEOUT_CYCLES=4, gnt never asserted -> o_bus_err pulses 4 cycles after REQ entry, stall released.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types for the memory-access stage: EX/MEM and MEM/WB register
// layouts, memory control fields and the stage FSM encoding.
package rv_pkg;

    typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_t;

    typedef struct packed {
        logic      mem_read;
        logic      mem_write;
        mem_size_t size;
        logic      is_unsigned;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        logic [63:0] alu_out;
        logic [63:0] read_data2;
        logic [4:0]  inst_rd;
        wb_ctrl_t    wb_ctrl;
        mem_ctrl_t   mem_ctrl;
    } ex_mem_regs_t;

    typedef struct packed {
        logic [63:0] alu_out;
        logic [63:0] mem_data;
        logic [4:0]  inst_rd;
        wb_ctrl_t    wb_ctrl;
    } mem_wb_regs_t;

    typedef enum logic [1:0] {MEM_IDLE, MEM_REQ, MEM_WAIT} mem_fsm_t;

    // Natural alignment: the low log2(size) address bits must be zero.
    function automatic logic addr_aligned(mem_size_t size, logic [2:0] off);
        logic ok;
        case (size)
            MEM_B:   ok = 1'b1;
            MEM_H:   ok = (off[0] == 1'b0);
            MEM_W:   ok = (off[1:0] == 2'b00);
            default: ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 64-bit data bus: store byte enables / replicated
// write data, and load extract + sign/zero extension. Purely combinational
// so a cache front-end can reuse it.
module mem_lane_align
    import rv_pkg::*;
(
    input  mem_size_t   i_size,
    input  logic        i_is_unsigned,
    input  logic [2:0]  i_off,
    input  logic [63:0] i_st_data,
    input  logic [63:0] i_ld_raw,
    output logic [7:0]  o_st_be,
    output logic [63:0] o_st_wdata,
    output logic [63:0] o_ld_data
);

    logic [63:0] ld_sh;

    // Store data is replicated so whichever lanes are enabled see the value;
    // load data is shifted down to bit 0 before truncation and extension.
    always_comb begin
        ld_sh      = i_ld_raw >> {i_off, 3'b000};
        o_st_be    = 8'hFF;
        o_st_wdata = i_st_data;
        o_ld_data  = ld_sh;
        case (i_size)
            MEM_B: begin
                o_st_be    = 8'h01 << i_off;
                o_st_wdata = {8{i_st_data[7:0]}};
                o_ld_data  = i_is_unsigned ? {56'b0, ld_sh[7:0]}
                                           : {{56{ld_sh[7]}}, ld_sh[7:0]};
            end
            MEM_H: begin
                o_st_be    = 8'h03 << i_off;
                o_st_wdata = {4{i_st_data[15:0]}};
                o_ld_data  = i_is_unsigned ? {48'b0, ld_sh[15:0]}
                                           : {{48{ld_sh[15]}}, ld_sh[15:0]};
            end
            MEM_W: begin
                o_st_be    = 8'h0F << i_off;
                o_st_wdata = {2{i_st_data[31:0]}};
                o_ld_data  = i_is_unsigned ? {32'b0, ld_sh[31:0]}
                                           : {{32{ld_sh[31]}}, ld_sh[31:0]};
            end
            default: begin
                o_st_be    = 8'hFF;
                o_st_wdata = i_st_data;
                o_ld_data  = ld_sh;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, req/gnt/rvalid data-memory port,
// upstream stall while an access is outstanding, misalignment trap.
// Optional MEM_STAGE_TIMEOUT_EN: abandon an access after TIMEOUT_CYCLES
// cycles outside IDLE and flag o_bus_err.
module mem_stage
    import rv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  ex_mem_regs_t i_ex_mem_regs,
    input  logic         i_valid,
    output logic         o_stall,
    output logic         o_dmem_req,
    output logic         o_dmem_we,
    output logic [63:0]  o_dmem_addr,
    output logic [63:0]  o_dmem_wdata,
    output logic [7:0]   o_dmem_be,
    input  logic         i_dmem_gnt,
    input  logic         i_dmem_rvalid,
    input  logic [63:0]  i_dmem_rdata,
    output mem_wb_regs_t o_mem_wb_regs,
    output logic         o_wb_valid,
    output logic         o_misaligned,
    output logic         o_bus_err
);

    // A zero timeout would fire before any grant could arrive.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_stage: TIMEOUT_CYCLES must be at least 1");
    end

    ex_mem_regs_t ex_q, ex_d;
    logic         vld_q, vld_d;
    mem_fsm_t     state_q, state_d;
    mem_wb_regs_t mem_wb_q, mem_wb_d;
    logic         wb_valid_q, wb_valid_d;
    logic         misal_q, misal_d;
    logic         bus_err_q, bus_err_d;

    logic         is_mem, aligned, stall, req, done, timeout;
    logic [2:0]   off;
    logic [7:0]   st_be;
    logic [63:0]  st_wdata, ld_data;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign off     = ex_q.alu_out[2:0];
    assign is_mem  = ex_q.mem_ctrl.mem_read | ex_q.mem_ctrl.mem_write;
    assign aligned = addr_aligned(ex_q.mem_ctrl.size, off);

    mem_lane_align u_align (
        .i_size        (ex_q.mem_ctrl.size),
        .i_is_unsigned (ex_q.mem_ctrl.is_unsigned),
        .i_off         (off),
        .i_st_data     (ex_q.read_data2),
        .i_ld_raw      (i_dmem_rdata),
        .o_st_be       (st_be),
        .o_st_wdata    (st_wdata),
        .o_ld_data     (ld_data)
    );

    // FSM next state, stall, capture and writeback result selection.
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        req        = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;
        ex_d       = ex_q;
        vld_d      = vld_q;
        mem_wb_d   = mem_wb_q;
        wb_valid_d = 1'b0;
        misal_d    = 1'b0;
        bus_err_d  = 1'b0;

        case (state_q)
            MEM_IDLE: begin
                // vld_q in IDLE always means a fresh, unprocessed instruction.
                if (vld_q && is_mem && aligned) begin
                    state_d = MEM_REQ;
                    stall   = 1'b1;
                end
            end
            MEM_REQ: begin
                req = 1'b1;
                if (i_dmem_gnt && i_dmem_rvalid) begin
                    done    = 1'b1;
                    state_d = MEM_IDLE;
                end else begin
                    stall = 1'b1;
                    if (i_dmem_gnt) state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (i_dmem_rvalid) begin
                    done    = 1'b1;
                    state_d = MEM_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = MEM_IDLE;
        endcase

`ifdef MEM_STAGE_TIMEOUT_EN
        cnt_d = (state_q == MEM_IDLE) ? '0 : cnt_q + 1'b1;
        if (state_q != MEM_IDLE && !done && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout = 1'b1;
            state_d = MEM_IDLE;
            stall   = 1'b0;
        end
`endif

        if (!stall) begin
            ex_d  = i_ex_mem_regs;
            vld_d = i_valid;
        end

        mem_wb_d.alu_out = ex_q.alu_out;
        mem_wb_d.inst_rd = ex_q.inst_rd;
        mem_wb_d.wb_ctrl = ex_q.wb_ctrl;
        mem_wb_d.mem_data = '0;
        if (state_q == MEM_IDLE && vld_q && !is_mem) begin
            wb_valid_d = 1'b1;
        end else if (state_q == MEM_IDLE && vld_q && !aligned) begin
            wb_valid_d = 1'b1;
            misal_d    = 1'b1;
            mem_wb_d.wb_ctrl.reg_write = 1'b0;
        end else if (done) begin
            wb_valid_d = 1'b1;
            if (ex_q.mem_ctrl.mem_read && !ex_q.mem_ctrl.mem_write) mem_wb_d.mem_data = ld_data;
        end else if (timeout) begin
            wb_valid_d = 1'b1;
            bus_err_d  = 1'b1;
            mem_wb_d.wb_ctrl.reg_write = 1'b0;
        end else begin
            mem_wb_d = mem_wb_q;
        end
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= MEM_IDLE;
            ex_q       <= '0;
            vld_q      <= 1'b0;
            mem_wb_q   <= '0;
            wb_valid_q <= 1'b0;
            misal_q    <= 1'b0;
            bus_err_q  <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ex_q       <= ex_d;
            vld_q      <= vld_d;
            mem_wb_q   <= mem_wb_d;
            wb_valid_q <= wb_valid_d;
            misal_q    <= misal_d;
            bus_err_q  <= bus_err_d;
`ifdef MEM_STAGE_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Bus signals are qualified by the request so the port idles at zero.
    assign o_stall       = stall;
    assign o_dmem_req    = req;
    assign o_dmem_we     = req & ex_q.mem_ctrl.mem_write;
    assign o_dmem_addr   = req ? {ex_q.alu_out[63:3], 3'b000} : 64'b0;
    assign o_dmem_wdata  = (req && ex_q.mem_ctrl.mem_write) ? st_wdata : 64'b0;
    assign o_dmem_be     = !req ? 8'h00 : (ex_q.mem_ctrl.mem_write ? st_be : 8'hFF);
    assign o_mem_wb_regs = mem_wb_q;
    assign o_wb_valid    = wb_valid_q;
    assign o_misaligned  = misal_q;
`ifdef MEM_STAGE_TIMEOUT_EN
    assign o_bus_err     = bus_err_q;
`else
    assign o_bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads with extension,
// store lane steering, wait states, misalignment, reset mid-access and
// (with MEM_STAGE_TIMEOUT_EN) the bus-error timeout.
module tb_mem_stage;
    import rv_pkg::*;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    ex_mem_regs_t i_ex_mem_regs = '0;
    logic         i_valid = 1'b0;
    logic         o_stall, o_dmem_req, o_dmem_we;
    logic [63:0]  o_dmem_addr, o_dmem_wdata;
    logic [7:0]   o_dmem_be;
    logic         i_dmem_gnt = 1'b0;
    logic         i_dmem_rvalid = 1'b0;
    logic [63:0]  i_dmem_rdata = '0;
    mem_wb_regs_t o_mem_wb_regs;
    logic         o_wb_valid, o_misaligned, o_bus_err;

    int checks = 0;
    int errors = 0;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_ex_mem_regs(i_ex_mem_regs), .i_valid(i_valid),
        .o_stall(o_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
        .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
        .o_mem_wb_regs(o_mem_wb_regs), .o_wb_valid(o_wb_valid),
        .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic ex_mem_regs_t mk(input logic [63:0] a, input logic [63:0] d,
                                        input logic rd_en, input logic wr_en,
                                        input mem_size_t sz, input logic uns);
        ex_mem_regs_t e;
        e.alu_out               = a;
        e.read_data2            = d;
        e.inst_rd               = 5'd7;
        e.wb_ctrl.reg_write     = !wr_en;
        e.wb_ctrl.mem_to_reg    = rd_en;
        e.mem_ctrl.mem_read     = rd_en;
        e.mem_ctrl.mem_write    = wr_en;
        e.mem_ctrl.size         = sz;
        e.mem_ctrl.is_unsigned  = uns;
        return e;
    endfunction

    // Load with grant and response in the first request cycle.
    task automatic do_load(input string tag, input ex_mem_regs_t e,
                           input logic [63:0] rdata, input logic [63:0] exp);
        i_ex_mem_regs = e; i_valid = 1'b1;
        tick(); i_valid = 1'b0;
        #2 chk({tag, "_stall_cap"}, o_stall, 1);
        chk({tag, "_noreq_cap"}, o_dmem_req, 0);
        tick(); i_dmem_gnt = 1'b1; i_dmem_rvalid = 1'b1; i_dmem_rdata = rdata;
        #2 chk({tag, "_req"}, o_dmem_req, 1);
        chk({tag, "_be"}, o_dmem_be, 8'hFF);
        chk({tag, "_we"}, o_dmem_we, 0);
        chk({tag, "_addr"}, o_dmem_addr, {e.alu_out[63:3], 3'b000});
        chk({tag, "_stall_rv"}, o_stall, 0);
        tick(); i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
        #2 chk({tag, "_wbv"}, o_wb_valid, 1);
        chk({tag, "_data"}, o_mem_wb_regs.mem_data, exp);
    endtask

    // Store with grant and ack in the first request cycle.
    task automatic do_store(input string tag, input ex_mem_regs_t e,
                            input logic [7:0] exp_be, input logic [63:0] exp_wd);
        i_ex_mem_regs = e; i_valid = 1'b1;
        tick(); i_valid = 1'b0;
        tick(); i_dmem_gnt = 1'b1; i_dmem_rvalid = 1'b1;
        #2 chk({tag, "_we"}, o_dmem_we, 1);
        chk({tag, "_be"}, o_dmem_be, exp_be);
        chk({tag, "_wdata"}, o_dmem_wdata, exp_wd);
        tick(); i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
        #2 chk({tag, "_wbv"}, o_wb_valid, 1);
        chk({tag, "_data0"}, o_mem_wb_regs.mem_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        #2 chk("rst_req", o_dmem_req, 0);
        chk("rst_we", o_dmem_we, 0);
        chk("rst_be", o_dmem_be, 0);
        chk("rst_addr", o_dmem_addr, 0);
        chk("rst_wdata", o_dmem_wdata, 0);
        chk("rst_wbv", o_wb_valid, 0);
        chk("rst_alu", o_mem_wb_regs.alu_out, 0);
        chk("rst_misal", o_misaligned, 0);
        chk("rst_buserr", o_bus_err, 0);
        i_rst = 1'b0;
        tick();

        // ALU op: writeback one cycle after capture, never stalls.
        i_ex_mem_regs = mk(64'h1234, 64'h0, 1'b0, 1'b0, MEM_D, 1'b0); i_valid = 1'b1;
        tick(); i_valid = 1'b0;
        #2 chk("alu_stall", o_stall, 0);
        chk("alu_wbv_early", o_wb_valid, 0);
        tick();
        #2 chk("alu_wbv", o_wb_valid, 1);
        chk("alu_out", o_mem_wb_regs.alu_out, 64'h1234);
        chk("alu_mdata", o_mem_wb_regs.mem_data, 0);
        chk("alu_rw", o_mem_wb_regs.wb_ctrl.reg_write, 1);
        chk("alu_stall2", o_stall, 0);
        tick();
        #2 chk("alu_wbv_pulse", o_wb_valid, 0);

        // Loads: sign / zero extension at various offsets.
        do_load("lb", mk(64'h1003, 0, 1, 0, MEM_B, 0), 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lbu", mk(64'h1007, 0, 1, 0, MEM_B, 1), 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB);
        do_load("lhu", mk(64'h1002, 0, 1, 0, MEM_H, 1), 64'h0000_0000_8001_0000, 64'h0000_0000_0000_8001);
        do_load("lw", mk(64'h1004, 0, 1, 0, MEM_W, 0), 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
        do_load("ld", mk(64'h1008, 0, 1, 0, MEM_D, 0), 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

        // Stores: lane enables and replication.
        do_store("sb", mk(64'h3005, 64'h99EF, 0, 1, MEM_B, 0), 8'h20, 64'hEFEF_EFEF_EFEF_EFEF);
        do_store("sw", mk(64'h3004, 64'h5511_2233_4455_6677, 0, 1, MEM_W, 0), 8'hF0, 64'h4455_6677_4455_6677);
        do_store("sd", mk(64'h3008, 64'hDEAD_BEEF_CAFE_F00D, 0, 1, MEM_D, 0), 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);

        // SH with a 3-cycle grant and the ack 2 cycles later.
        i_ex_mem_regs = mk(64'h2006, 64'hABCD, 0, 1, MEM_H, 0); i_valid = 1'b1;
        tick(); i_valid = 1'b0;
        #2 chk("sh_stall_cap", o_stall, 1);
        for (int c = 0; c < 3; c++) begin
            tick(); i_dmem_gnt = (c == 2);
            #2 chk("sh_req", o_dmem_req, 1);
            chk("sh_addr", o_dmem_addr, 64'h2000);
            chk("sh_be", o_dmem_be, 8'hC0);
            chk("sh_wdata", o_dmem_wdata, 64'hABCD_ABCD_ABCD_ABCD);
            chk("sh_stall_req", o_stall, 1);
        end
        tick(); i_dmem_gnt = 1'b0;
        #2 chk("sh_wait_req", o_dmem_req, 0);
        chk("sh_wait_stall", o_stall, 1);
        tick(); i_dmem_rvalid = 1'b1;
        i_ex_mem_regs = mk(64'h5555, 0, 0, 0, MEM_D, 0); i_valid = 1'b1;
        #2 chk("sh_rv_stall", o_stall, 0);
        tick(); i_dmem_rvalid = 1'b0; i_valid = 1'b0;
        #2 chk("sh_wbv", o_wb_valid, 1);
        chk("sh_alu", o_mem_wb_regs.alu_out, 64'h2006);
        chk("sh_mdata", o_mem_wb_regs.mem_data, 0);
        tick();
        #2 chk("sh_next_wbv", o_wb_valid, 1);
        chk("sh_next_alu", o_mem_wb_regs.alu_out, 64'h5555);
        tick();

        // Misaligned LW and SD: trap, no bus traffic, reg_write dropped.
        i_ex_mem_regs = mk(64'h1002, 0, 1, 0, MEM_W, 0); i_valid = 1'b1;
        tick(); i_valid = 1'b0;
        #2 chk("mis_lw_stall", o_stall, 0);
        chk("mis_lw_req", o_dmem_req, 0);
        tick();
        #2 chk("mis_lw_flag", o_misaligned, 1);
        chk("mis_lw_wbv", o_wb_valid, 1);
        chk("mis_lw_rw", o_mem_wb_regs.wb_ctrl.reg_write, 0);
        chk("mis_lw_req2", o_dmem_req, 0);
        tick();
        #2 chk("mis_lw_pulse", o_misaligned, 0);
        i_ex_mem_regs = mk(64'h1004, 64'h1, 0, 1, MEM_D, 0); i_valid = 1'b1;
        tick(); i_valid = 1'b0;
        #2 chk("mis_sd_req", o_dmem_req, 0);
        tick();
        #2 chk("mis_sd_flag", o_misaligned, 1);
        tick();

        // Reset while waiting for the response; stray rvalid afterwards.
        i_ex_mem_regs = mk(64'h4000, 0, 1, 0, MEM_D, 0); i_valid = 1'b1;
        tick(); i_valid = 1'b0;
        tick(); i_dmem_gnt = 1'b1;
        tick(); i_dmem_gnt = 1'b0;
        #2 chk("rstw_stall", o_stall, 1);
        i_rst = 1'b1;
        tick(); i_rst = 1'b0;
        #2 chk("rstw_req", o_dmem_req, 0);
        chk("rstw_stall0", o_stall, 0);
        chk("rstw_wbv", o_wb_valid, 0);
        chk("rstw_be", o_dmem_be, 0);
        chk("rstw_alu", o_mem_wb_regs.alu_out, 0);
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'h77;
        tick(); i_dmem_rvalid = 1'b0;
        #2 chk("stray_wbv", o_wb_valid, 0);
        tick();
        #2 chk("stray_wbv2", o_wb_valid, 0);

        // Request never granted.
        i_ex_mem_regs = mk(64'h5000, 0, 1, 0, MEM_D, 0); i_valid = 1'b1;
        tick(); i_valid = 1'b0;
        tick();
`ifdef MEM_STAGE_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            #2 chk("to_stall", o_stall, (c < 3) ? 1 : 0);
            chk("to_buserr_early", o_bus_err, 0);
            tick();
        end
        #2 chk("to_buserr", o_bus_err, 1);
        chk("to_wbv", o_wb_valid, 1);
        chk("to_rw", o_mem_wb_regs.wb_ctrl.reg_write, 0);
        chk("to_req", o_dmem_req, 0);
        tick();
        #2 chk("to_pulse", o_bus_err, 0);
        chk("to_stall_rel", o_stall, 0);
`else
        for (int c = 0; c < 6; c++) begin
            #2 chk("nto_stall", o_stall, 1);
            chk("nto_req", o_dmem_req, 1);
            chk("nto_buserr", o_bus_err, 0);
            tick();
        end
        i_dmem_gnt = 1'b1; i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'h42;
        tick(); i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
        #2 chk("nto_wbv", o_wb_valid, 1);
        chk("nto_data", o_mem_wb_regs.mem_data, 64'h42);
`endif
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
